// File: rtl/seven_segment_scan_ctrl.sv
// Scan controller for an N-digit seven-segment display sharing one combinational ROM; FETCH/SHOW/BLANK per digit.
// Latency: ROM pattern visible the cycle after FETCH; new values are committed at frame wrap or while idle.
// Backpressure: wr_ready drops while a value is pending. Optional macro LEADING_ZERO_BLANK_EN suppresses leading-zero digits.
module seven_segment_scan_ctrl #(
  parameter int          NUM_DIGITS   = 4,
  parameter int          SCAN_DIV     = 1000,
  parameter int          BLANK_CYCLES = 8,
  parameter logic [7:0]  SEG_IDLE     = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    wr_valid,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  output logic                    wr_ready,
  output logic [3:0]              rom_addr,
  input  logic [7:0]              rom_data,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NUM_DIGITS);
  localparam int DW      = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHOW, BLANK} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] den_q, den_d;
  logic [DW-1:0]         active_q, pend_q;
  logic                  pend_full_q;
  logic                  wrap;
  logic                  suppress;
  logic                  commit;
  logic                  accept;

  assign rom_addr = active_q[{idx_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blanked when it and every more-significant nibble are zero.
  logic [DW-1:0] upper;
  assign upper    = active_q >> {idx_q, 2'b00};
  assign suppress = (idx_q != '0) && (upper == '0);
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    den_d   = den_q;
    wrap    = 1'b0;
    if (!enable || state_q == IDLE) begin
      state_d = enable ? FETCH : IDLE;
      idx_d   = '0;
      seg_d   = SEG_IDLE;
      den_d   = '0;
    end else begin
      case (state_q)
        FETCH: begin
          seg_d   = suppress ? SEG_IDLE : rom_data;
          den_d   = suppress ? '0 : (NUM_DIGITS'(1) << idx_q);
          cnt_d   = SHOW_LAST;
          state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == '0) begin
            seg_d   = SEG_IDLE;
            den_d   = '0;
            cnt_d   = BLANK_LAST;
            state_d = BLANK;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        BLANK: begin
          if (cnt_q == '0) begin
            state_d = FETCH;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pending value only moves to the active register between frames so a frame is never torn.
  assign commit = pend_full_q && (wrap || state_q == IDLE);
  assign accept = wr_valid && !pend_full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      seg_q       <= SEG_IDLE;
      den_q       <= '0;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      den_q   <= den_d;
      if (commit) begin
        active_q    <= pend_q;
        pend_full_q <= 1'b0;
      end else if (accept) begin
        pend_q      <= wr_data;
        pend_full_q <= 1'b1;
      end
    end
  end

  assign wr_ready   = !pend_full_q;
  assign seg_out    = seg_q;
  assign digit_en   = den_q;
  assign frame_done = wrap;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Bench for seven_segment_scan_ctrl: a slot-timing model predicts every output each cycle, plus directed literal checks.
module tb_seven_segment_scan_ctrl;

  localparam int N      = 4;
  localparam int PERIOD = 7;   // 1 fetch + 4 show + 2 blank
  localparam int FRAME  = N * PERIOD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          wr_valid = 1'b0;
  logic [15:0]   wr_data = '0;
  logic          wr_ready;
  logic [3:0]    rom_addr;
  logic [7:0]    rom_data;
  logic [7:0]    seg_out;
  logic [N-1:0]  digit_en;
  logic          frame_done;

  int nvec = 0;
  int nerr = 0;
  bit chk  = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [3:0] a);
    logic [7:0] tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    return tbl[a];
  endfunction

  assign rom_data = rom(rom_addr);

  seven_segment_scan_ctrl #(
    .NUM_DIGITS(N), .SCAN_DIV(4), .BLANK_CYCLES(2), .SEG_IDLE(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .seg_out(seg_out), .digit_en(digit_en), .frame_done(frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time since scan start decides the slot; active/pending tracked as plain values.
  bit        m_run;
  int        m_t;
  logic [15:0] m_act, m_pend;
  bit        m_full;
  int        cyc = 0;
  int        last_fd = -1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_t = 0; m_act = '0; m_pend = '0; m_full = 0;
    end else begin
      if (m_full && (!m_run || (enable && m_t % FRAME == FRAME - 1))) begin
        m_act  = m_pend;
        m_full = 0;
      end else if (wr_valid && !m_full) begin
        m_pend = wr_data;
        m_full = 1;
      end
      if (!enable)     m_run = 0;
      else if (!m_run) begin m_run = 1; m_t = 0; end
      else             m_t = m_t + 1;
    end
  end

  function automatic bit suppressed(input int d, input logic [15:0] v);
`ifdef LEADING_ZERO_BLANK_EN
    return (d > 0) && ((v >> (4 * d)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (chk) begin
      int ph, d;
      logic [7:0]   e_seg;
      logic [N-1:0] e_den;
      ph = m_t % PERIOD;
      d  = m_run ? (m_t / PERIOD) % N : 0;
      e_seg = 8'h00;
      e_den = '0;
      if (m_run && ph >= 1 && ph <= 4 && !suppressed(d, m_act)) begin
        e_seg = rom(4'((m_act >> (4 * d)) & 16'hF));
        e_den = N'(1) << d;
      end
      check("seg_out", 32'(seg_out), 32'(e_seg));
      check("digit_en", 32'(digit_en), 32'(e_den));
      check("frame_done", 32'(frame_done), 32'(m_run && enable && (m_t % FRAME == FRAME - 1)));
      check("wr_ready", 32'(wr_ready), 32'(!m_full));
      check("rom_addr", 32'(rom_addr), 32'((m_act >> (4 * d)) & 16'hF));
      if (!enable || !rst_n) last_fd = -1;
      else if (frame_done) begin
        if (last_fd >= 0) check("frame_period", 32'(cyc - last_fd), 32'(FRAME));
        last_fd = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_write(input logic [15:0] d, input int budget, output int waited);
    wr_valid = 1'b1;
    wr_data  = d;
    waited   = 0;
    while (!wr_ready && waited < budget) begin tick(1); waited++; end
    if (!wr_ready) check("write_timeout", 32'(wr_ready), 32'd1);
    tick(1);
    wr_valid = 1'b0;
  endtask

  initial begin
    int w;
    #3 rst_n = 1'b0;
    #1;
    check("rst_seg", 32'(seg_out), 32'h00);
    check("rst_den", 32'(digit_en), 32'h0);
    check("rst_rdy", 32'(wr_ready), 32'd1);
    check("rst_fd", 32'(frame_done), 32'd0);
    chk = 1'b1;
    @(posedge clk); tick(1);
    rst_n = 1'b1;

    do_write(16'h3210, 10, w);
    tick(1);
    check("idle_commit_rdy", 32'(wr_ready), 32'd1);
    enable = 1'b1;
    tick(2);                                  // t=1, digit 0 first SHOW cycle
    check("d0_den", 32'(digit_en), 32'b0001);
    check("d0_seg", 32'(seg_out), 32'h3F);
    tick(21);                                 // t=22, digit 3
    check("d3_den", 32'(digit_en), 32'b1000);
    check("d3_seg", 32'(seg_out), 32'h4F);

    tick(14);                                 // t=36, frame 1 digit 1
    check("f1d1_den", 32'(digit_en), 32'b0010);
    check("f1d1_seg", 32'(seg_out), 32'h06);
    do_write(16'hABCD, 10, w);
    check("busy_rdy", 32'(wr_ready), 32'd0);
    do_write(16'h1234, 60, w);                // stalled until wrap commit
    check("stall_cycles", 32'(w), 32'd19);
    check("f2d0_den", 32'(digit_en), 32'b0001);
    check("f2d0_seg", 32'(seg_out), 32'h5E);  // ROM(D)

    tick(14);                                 // frame 2 digit 2
    check("f2d2_seg", 32'(seg_out), 32'h7C);  // ROM(B)
    enable = 1'b0;
    tick(1);
    check("off_den", 32'(digit_en), 32'h0);
    check("off_seg", 32'(seg_out), 32'h00);
    check("off_fd", 32'(frame_done), 32'd0);
    tick(2);
    enable = 1'b1;
    tick(2);
    check("reen_den", 32'(digit_en), 32'b0001);
    check("reen_seg", 32'(seg_out), 32'h66);  // 1234 committed while idle

    tick(1);
    do_write(16'h5555, 10, w);
    #2 rst_n = 1'b0;
    #1;
    check("arst_seg", 32'(seg_out), 32'h00);
    check("arst_den", 32'(digit_en), 32'h0);
    check("arst_rdy", 32'(wr_ready), 32'd1);
    check("arst_fd", 32'(frame_done), 32'd0);
    @(posedge clk); tick(1);
    rst_n = 1'b1;
    check("arst_addr", 32'(rom_addr), 32'h0);
    tick(2);
    check("post_rst_seg", 32'(seg_out), 32'h3F);
    check("post_rst_den", 32'(digit_en), 32'b0001);

    enable = 1'b0;
    tick(1);
    do_write(16'h0005, 10, w);
    tick(1);
    enable = 1'b1;
    tick(2);
    check("lz_d0_seg", 32'(seg_out), 32'h6D);
    tick(7);                                  // digit 1 SHOW slot
`ifdef LEADING_ZERO_BLANK_EN
    check("lz_d1_den", 32'(digit_en), 32'h0);
    check("lz_d1_seg", 32'(seg_out), 32'h00);
`else
    check("lz_d1_den", 32'(digit_en), 32'b0010);
    check("lz_d1_seg", 32'(seg_out), 32'h3F);
`endif
    tick(60);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
